gt_stamp_arb: RTL and testbench
===============================

Name: gt_stamp_arb

Overview:
- Shares one global-time latch (25-bit {gt, phase} result) between up to 8 trigger requesters.
- Requests are queued as sticky pending bits and granted round-robin.
- For each grant the block pulses the latch trigger, waits a fixed settle time, and captures the latched value tagged with the requester ID.
- Captured stamps go into a small first-word-fall-through FIFO and are read out over a valid/ready handshake.
- Sits between channel trigger logic and the readout formatter.

Parameters:
NREQ, 4, number of requesters (2..8)
SETTLE, 3, clk cycles from trig pulse until gtin is stable
DEPTH, 8, FIFO depth in entries (power of 2, 2..64)

Ports:
clk  input  1  system clock
reset  input  1  synchronous, active-high reset
req  input  NREQ  per-requester stamp request; sampled each clk, high level sets pending
trig  output  1  one-cycle strobe to the time latch
gtin  input  25  latched {gt, phase} returned by the latch
out_gt  output  25  time stamp at FIFO head
out_id  output  3  requester index at FIFO head
out_valid  output  1  FIFO not empty
out_ready  input  1  consumer accepts head entry
fifo_cnt  output  7  entries held (0..DEPTH)
overflow  output  8  dropped-stamp counter, saturates at 255
busy  output  1  FSM not IDLE, or any pending bit set

Behaviour:
- Reset, applied synchronously at any time including mid-sequence:
  - pending=0, FSM=IDLE, rr pointer=0.
  - FIFO emptied; trig, out_valid, fifo_cnt, overflow, busy all 0. out_gt and out_id read 0.
  - A request in flight is discarded and produces no FIFO entry.
- Pending: pending[i] <= pending[i] | req[i], cleared only when i is granted.
  - A request for i while pending[i]=1 coalesces; no extra stamp.
  - A request for i arriving in the grant cycle itself sets pending[i] again after the clear, so it yields a new stamp.
- FSM states: IDLE, TRIG, WAIT, CAPT.
  - IDLE: if pending!=0, grant the first set bit searching upward from rr, modulo NREQ. Latch gid, clear pending[gid], set rr=(gid+1) mod NREQ, go to TRIG.
  - TRIG: trig=1 for exactly this cycle. Load wait counter with SETTLE, go to WAIT.
  - WAIT: decrement the counter; leave for CAPT when it reaches 1. WAIT lasts exactly SETTLE cycles.
  - CAPT: sample gtin and push {gid, gtin} into the FIFO, then go to IDLE.
- Latency: req high in cycle t, pending visible t+1, trig high t+2, CAPT at t+3+SETTLE. out_valid rises at t+4+SETTLE if the FIFO was empty.
- Minimum trig spacing for back-to-back grants is SETTLE+3 cycles: 6 with the defaults.
- FIFO:
  - Pop on out_valid & out_ready.
  - Push in CAPT succeeds when fifo_cnt<DEPTH, or when fifo_cnt==DEPTH and a pop happens in the same cycle.
  - Otherwise the entry is dropped and overflow increments, saturating at 255.
  - Simultaneous push and pop leaves fifo_cnt unchanged.
  - Pointers wrap modulo DEPTH.
  - out_gt and out_id are valid only while out_valid=1, and hold steady while out_valid & !out_ready.
- Requester bits at or above NREQ do not exist; out_id upper bits are 0.

Test Plan:
- Reset, then req[1] pulsed one cycle at t=0 → trig only in cycle 2; gtin=0x0ABCDEF held in cycle 6 → out_valid at cycle 7 with out_id=1, out_gt=0x0ABCDEF, fifo_cnt=1. With out_ready=1 the entry pops and out_valid=0 at cycle 8.
- req=4'b1111 for one cycle after reset → trig at cycles 2, 8, 14, 20. FIFO order is ids 0,1,2,3, each with the gtin value present in its CAPT cycle (6, 12, 18, 24). busy=0 after cycle 24.
- After a grant of id 2 (rr=3), assert req[0] and req[3] together → id 3 is granted first, then id 0. A repeated req[3] during its WAIT gives a third stamp, id 3.
- out_ready=0, requests issued until 10 captures occur with DEPTH=8 → fifo_cnt=8, overflow=2, and the first 8 stamps are retained in order. Then pulse out_ready=1 during a CAPT cycle with FIFO full → push succeeds, fifo_cnt stays 8, overflow stays 2.
- Assert reset during WAIT with pending[3]=1 and 2 FIFO entries → on the next cycle all outputs are 0 and pending is cleared. No trig follows unless a new req arrives, and the next grant searches from id 0.
- Hold req[0]=1 continuously → trig repeats every 6 cycles and overflow saturates at 255 after prolonged out_ready=0, never wrapping.

Source files
------------

// File: rtl/gt_stamp_arb.sv
// Round-robin arbiter sharing one global-time latch between NREQ requesters.
// Each grant pulses trig, waits SETTLE cycles, then queues {id, gtin} in a FWFT FIFO.
module gt_stamp_arb #(
    parameter int NREQ   = 4,
    parameter int SETTLE = 3,
    parameter int DEPTH  = 8
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [NREQ-1:0] req,
    output logic            trig,
    input  logic [24:0]     gtin,
    output logic [24:0]     out_gt,
    output logic [2:0]      out_id,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [6:0]      fifo_cnt,
    output logic [7:0]      overflow,
    output logic            busy
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(SETTLE + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_TRIG,
        S_WAIT,
        S_CAPT
    } state_t;

    state_t          r_state;
    logic [NREQ-1:0] r_pending;
    logic [2:0]      r_rr;
    logic [2:0]      r_gid;
    logic [CW-1:0]   r_wait;
    logic            r_trig;
    logic [AW-1:0]   r_wr_ptr;
    logic [AW-1:0]   r_rd_ptr;
    logic [6:0]      r_cnt;
    logic [7:0]      r_ovf;
    logic [27:0]     r_mem [DEPTH];

    logic            w_hit_hi;
    logic            w_hit_lo;
    logic [2:0]      w_id_hi;
    logic [2:0]      w_id_lo;
    logic [2:0]      w_gnt;
    logic [2:0]      w_rr_next;
    logic            w_grant;
    logic [NREQ-1:0] w_clr;
    logic            w_valid;
    logic            w_pop;
    logic            w_full;
    logic            w_capt;
    logic            w_push;
    logic [27:0]     w_head;

    // Round-robin pick: the lowest pending id at or above r_rr wins, otherwise
    // the lowest pending id below it (the wrap-around half of the search).
    // NOTE: every signal assigned in always_comb gets a default first so no
    // path leaves it unassigned and no latch is inferred.
    always_comb begin
        w_hit_hi = 1'b0;
        w_hit_lo = 1'b0;
        w_id_hi  = '0;
        w_id_lo  = '0;
        for (int j = 0; j < NREQ; j++) begin
            if (r_pending[j]) begin
                if (3'(j) >= r_rr) begin
                    if (!w_hit_hi) begin
                        w_hit_hi = 1'b1;
                        w_id_hi  = 3'(j);
                    end
                end else if (!w_hit_lo) begin
                    w_hit_lo = 1'b1;
                    w_id_lo  = 3'(j);
                end
            end
        end
    end

    assign w_gnt     = w_hit_hi ? w_id_hi : w_id_lo;
    assign w_rr_next = (w_gnt == 3'(NREQ - 1)) ? 3'd0 : w_gnt + 3'd1;
    assign w_grant   = (r_state == S_IDLE) && (|r_pending);
    assign w_clr     = w_grant ? (NREQ'(1) << w_gnt) : '0;

    assign w_valid = (r_cnt != 7'd0);
    assign w_pop   = w_valid && out_ready;
    assign w_full  = (r_cnt == 7'(DEPTH));
    assign w_capt  = (r_state == S_CAPT);
    // A full FIFO still accepts the capture when its head leaves in the same cycle.
    assign w_push  = w_capt && (!w_full || w_pop);

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= S_IDLE;
            r_pending <= '0;
            r_rr      <= '0;
            r_gid     <= '0;
            r_wait    <= '0;
            r_trig    <= 1'b0;
            r_wr_ptr  <= '0;
            r_rd_ptr  <= '0;
            r_cnt     <= '0;
            r_ovf     <= '0;
        end else begin
            // A request arriving in its own grant cycle re-arms the bit after the clear.
            r_pending <= (r_pending & ~w_clr) | req;
            r_trig    <= 1'b0;

            case (r_state)
                S_IDLE: begin
                    if (w_grant) begin
                        r_gid   <= w_gnt;
                        r_rr    <= w_rr_next;
                        r_trig  <= 1'b1;
                        r_state <= S_TRIG;
                    end
                end
                S_TRIG: begin
                    r_wait  <= CW'(SETTLE);
                    r_state <= S_WAIT;
                end
                S_WAIT: begin
                    if (r_wait == CW'(1)) begin
                        r_state <= S_CAPT;
                    end else begin
                        r_wait <= r_wait - CW'(1);
                    end
                end
                S_CAPT: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase

            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            if (w_push && !w_pop) begin
                r_cnt <= r_cnt + 7'd1;
            end else if (!w_push && w_pop) begin
                r_cnt <= r_cnt - 7'd1;
            end

            if (w_capt && !w_push && (r_ovf != 8'hFF)) begin
                r_ovf <= r_ovf + 8'd1;
            end
        end
    end

    // NOTE: the storage array has no reset; emptiness is tracked by r_cnt and
    // the outputs are forced to zero while the FIFO is empty.
    always_ff @(posedge clk) begin
        if (w_push && !reset) begin
            r_mem[r_wr_ptr] <= {r_gid, gtin};
        end
    end

    assign w_head    = r_mem[r_rd_ptr];
    assign out_valid = w_valid;
    assign out_gt    = w_valid ? w_head[24:0]  : '0;
    assign out_id    = w_valid ? w_head[27:25] : '0;
    assign fifo_cnt  = r_cnt;
    assign overflow  = r_ovf;
    assign trig      = r_trig;
    assign busy      = (r_state != S_IDLE) || (|r_pending);

endmodule

// File: tb/tb_gt_stamp_arb.sv
// Directed bench for gt_stamp_arb: a per-cycle vector table for the single-stamp
// path, then hand-written sequences for arbitration, overflow, reset and saturation.
module tb_gt_stamp_arb;

    localparam logic [24:0] BASE = 25'h100000;

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  req;
    logic        trig;
    logic [24:0] gtin;
    logic [24:0] out_gt;
    logic [2:0]  out_id;
    logic        out_valid;
    logic        out_ready;
    logic [6:0]  fifo_cnt;
    logic [7:0]  overflow;
    logic        busy;

    int           n_cmp = 0;
    int           n_err = 0;
    int           cyc   = 0;
    logic [127:0] trig_hist;

    typedef struct {
        logic [3:0]  req;
        logic [24:0] gtin;
        logic        rdy;
        logic        trig;
        logic        valid;
        logic [2:0]  id;
        logic [24:0] gt;
        logic [6:0]  cnt;
        logic        busy;
    } vec_t;

    vec_t tbl [9];

    gt_stamp_arb #(.NREQ(4), .SETTLE(3), .DEPTH(8)) dut (
        .clk       (clk),
        .reset     (reset),
        .req       (req),
        .trig      (trig),
        .gtin      (gtin),
        .out_gt    (out_gt),
        .out_id    (out_id),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .fifo_cnt  (fifo_cnt),
        .overflow  (overflow),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Advance one cycle; inputs are then driven and outputs sampled 1 time unit after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
        gtin = BASE + 25'(cyc);
        if (trig && cyc < 128) trig_hist[7'(cyc)] = 1'b1;
    endtask

    task automatic do_reset();
        reset     = 1'b1;
        req       = '0;
        out_ready = 1'b0;
        gtin      = '0;
        repeat (2) @(posedge clk);
        #1;
        reset     = 1'b0;
        cyc       = 0;
        gtin      = BASE;
        trig_hist = '0;
    endtask

    task automatic pop_check(input string name, input logic [2:0] id, input logic [24:0] gt);
        out_ready = 1'b1;
        check(name, 64'({out_valid, out_id, out_gt}), 64'({1'b1, id, gt}));
        tick();
        out_ready = 1'b0;
    endtask

    function automatic vec_t mk(input logic [3:0] r, input logic [24:0] g, input logic rd,
                                input logic t, input logic v, input logic [2:0] id,
                                input logic [24:0] gt, input logic [6:0] c, input logic b);
        vec_t x;
        x.req = r; x.gtin = g; x.rdy = rd; x.trig = t; x.valid = v;
        x.id = id; x.gt = gt; x.cnt = c; x.busy = b;
        return x;
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int          n_trig;
        int          bad_spacing;
        int          wrapped;
        logic [7:0]  prev_ovf;
        logic [63:0] exp_hist;

        //            req      gtin          rdy  trig v  id  gt            cnt  busy
        tbl[0] = mk(4'b0010, 25'h0000000, 1'b0, 1'b0, 1'b0, 3'd0, 25'h0,         7'd0, 1'b0);
        tbl[1] = mk(4'b0000, 25'h0000000, 1'b0, 1'b0, 1'b0, 3'd0, 25'h0,         7'd0, 1'b1);
        tbl[2] = mk(4'b0000, 25'h0000000, 1'b0, 1'b1, 1'b0, 3'd0, 25'h0,         7'd0, 1'b1);
        tbl[3] = mk(4'b0000, 25'h0000000, 1'b0, 1'b0, 1'b0, 3'd0, 25'h0,         7'd0, 1'b1);
        tbl[4] = mk(4'b0000, 25'h0000000, 1'b0, 1'b0, 1'b0, 3'd0, 25'h0,         7'd0, 1'b1);
        tbl[5] = mk(4'b0000, 25'h1FFFFFF, 1'b0, 1'b0, 1'b0, 3'd0, 25'h0,         7'd0, 1'b1);
        tbl[6] = mk(4'b0000, 25'h0ABCDEF, 1'b0, 1'b0, 1'b0, 3'd0, 25'h0,         7'd0, 1'b1);
        tbl[7] = mk(4'b0000, 25'h1555555, 1'b1, 1'b0, 1'b1, 3'd1, 25'h0ABCDEF,   7'd1, 1'b0);
        tbl[8] = mk(4'b0000, 25'h0000000, 1'b0, 1'b0, 1'b0, 3'd0, 25'h0,         7'd0, 1'b0);

        // Single stamp for requester 1, cycle by cycle.
        do_reset();
        check("reset_outputs", 64'({trig, out_valid, out_id, out_gt, fifo_cnt, overflow, busy}), 64'd0);
        for (int i = 0; i < 9; i++) begin
            req       = tbl[i].req;
            gtin      = tbl[i].gtin;
            out_ready = tbl[i].rdy;
            check($sformatf("single_c%0d", i),
                  64'({trig, out_valid, out_id, out_gt, fifo_cnt, busy}),
                  64'({tbl[i].trig, tbl[i].valid, tbl[i].id, tbl[i].gt, tbl[i].cnt, tbl[i].busy}));
            tick();
        end
        out_ready = 1'b0;

        // All four requesters at once: ids 0..3 at trig spacing 6.
        do_reset();
        req = 4'b1111;
        tick();
        req = '0;
        while (cyc < 24) tick();
        check("all4_busy_c24", 64'(busy), 64'd1);
        tick();
        check("all4_busy_c25", 64'(busy), 64'd0);
        check("all4_trig_cycles", 64'(trig_hist[31:0]), 64'h00104104);
        check("all4_cnt", 64'(fifo_cnt), 64'd4);
        for (int k = 0; k < 4; k++)
            pop_check($sformatf("all4_pop%0d", k), 3'(k), BASE + 25'(6 + 6 * k));

        // Round-robin resumes after id 2; re-request of id 3 during its WAIT.
        do_reset();
        req = 4'b0100;
        tick();
        req = '0;
        while (cyc < 8) tick();
        req = 4'b1001;
        tick();
        req = '0;
        while (cyc < 12) tick();
        req = 4'b1000;
        tick();
        req = '0;
        while (cyc < 28) tick();
        check("rr_trig_cycles", 64'(trig_hist[31:0]), 64'h00410404);
        check("rr_cnt", 64'(fifo_cnt), 64'd4);
        pop_check("rr_pop0", 3'd2, BASE + 25'd6);
        pop_check("rr_pop1", 3'd3, BASE + 25'd14);
        pop_check("rr_pop2", 3'd0, BASE + 25'd20);
        pop_check("rr_pop3", 3'd3, BASE + 25'd26);

        // FIFO overflow: 10 captures into 8 entries, then push-with-pop while full.
        do_reset();
        req = 4'b0001;
        repeat (55) tick();
        req = '0;
        while (cyc < 61) tick();
        check("ovf_cnt_full", 64'({fifo_cnt, overflow, busy}), 64'({7'd8, 8'd2, 1'b0}));
        while (cyc < 62) tick();
        req = 4'b0001;
        tick();
        req = '0;
        while (cyc < 68) tick();
        out_ready = 1'b1;
        check("ovf_head_c68", 64'(out_gt), 64'(BASE + 25'd6));
        tick();
        out_ready = 1'b0;
        check("ovf_push_pop_full", 64'({fifo_cnt, overflow}), 64'({7'd8, 8'd2}));
        for (int k = 0; k < 7; k++)
            pop_check($sformatf("ovf_pop%0d", k), 3'd0, BASE + 25'(12 + 6 * k));
        pop_check("ovf_pop7", 3'd0, BASE + 25'd68);
        check("ovf_empty", 64'({out_valid, fifo_cnt}), 64'd0);

        // Reset during WAIT with pending[3] set and two stamps queued.
        do_reset();
        req = 4'b0001;
        tick();
        req = '0;
        while (cyc < 7) tick();
        req = 4'b0010;
        tick();
        req = '0;
        while (cyc < 14) tick();
        req = 4'b0001;
        tick();
        req = '0;
        while (cyc < 17) tick();
        req = 4'b1000;
        tick();
        req = '0;
        check("mid_pre_reset", 64'({fifo_cnt, busy}), 64'({7'd2, 1'b1}));
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("mid_reset_outputs",
              64'({trig, out_valid, out_id, out_gt, fifo_cnt, overflow, busy}), 64'd0);
        while (cyc < 31) tick();
        check("mid_idle_busy", 64'(busy), 64'd0);
        req = 4'b1001;
        tick();
        req = '0;
        while (cyc < 44) tick();
        exp_hist = (64'd1 << 2) | (64'd1 << 9) | (64'd1 << 16) | (64'd1 << 33) | (64'd1 << 39);
        check("mid_trig_cycles", trig_hist[63:0], exp_hist);
        check("mid_cnt", 64'(fifo_cnt), 64'd2);
        pop_check("mid_pop0", 3'd0, BASE + 25'd37);
        pop_check("mid_pop1", 3'd3, BASE + 25'd43);

        // Continuous req[0]: fixed trig period, overflow saturates at 255.
        do_reset();
        req         = 4'b0001;
        n_trig      = 0;
        bad_spacing = 0;
        wrapped     = 0;
        prev_ovf    = '0;
        while (cyc < 1800) begin
            tick();
            if (trig) begin
                n_trig++;
                if (cyc % 6 != 2) bad_spacing++;
            end
            if (overflow < prev_ovf) wrapped++;
            prev_ovf = overflow;
            if (cyc == 103)  check("sat_ovf_c103", 64'(overflow), 64'd9);
            if (cyc == 1578) check("sat_ovf_c1578", 64'(overflow), 64'd254);
            if (cyc == 1579) check("sat_ovf_c1579", 64'(overflow), 64'd255);
        end
        req = '0;
        check("sat_trig_count", 64'(n_trig), 64'd300);
        check("sat_trig_spacing", 64'(bad_spacing), 64'd0);
        check("sat_no_wrap", 64'(wrapped), 64'd0);
        check("sat_final", 64'({overflow, fifo_cnt}), 64'({8'd255, 7'd8}));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
